vend_transaction: RTL and testbench

- Transaction controller directly downstream of the money-fetch stage (getMoney).
- Drives that stage's `mode` select and captures its 4-bit `value` output, first for customer money and then for machine money.
- Evaluates the purchase against the price of the selected product.
- Produces dispense/refund decisions, change, status, and a write-back request for the updated machine money.

---
 rtl/vend_pkg.sv | 26 ++
 rtl/vend_evaluate.sv | 46 ++++
 rtl/vend_transaction.sv | 139 +++++++++++++
 tb/tb_vend_transaction.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vending transaction controller: FSM states, result codes
// and the mode encoding of the money-fetch stage.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_CUST = 3'd1,
        CAP_CUST = 3'd2,
        REQ_MACH = 3'd3,
        CAP_MACH = 3'd4,
        EVAL     = 3'd5,
        DONE     = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OK           = 3'd0,
        INSUFFICIENT = 3'd1,
        NO_CHANGE    = 3'd2,
        FULL         = 3'd3,
        CANCEL       = 3'd4
    } status_t;

    localparam logic MODE_MACHINE  = 1'b0;
    localparam logic MODE_CUSTOMER = 1'b1;

endpackage

// File: rtl/vend_evaluate.sv
// Purchase decision: compares captured customer/machine money against the price
// and produces the sale outcome. Purely combinational.
module vend_evaluate
    import vend_pkg::*;
#(
    parameter int MONEY_W = 4
) (
    input  logic [MONEY_W-1:0] cust_i,
    input  logic [MONEY_W-1:0] mach_i,
    input  logic [MONEY_W-1:0] price_i,
    output logic               dispense_o,
    output logic [MONEY_W-1:0] change_o,
    output logic [MONEY_W-1:0] new_mach_o,
    output status_t            status_o
);

    localparam logic [MONEY_W:0] MAX_V = {1'b0, {MONEY_W{1'b1}}};

    // One extra bit so the difference and sum never wrap silently.
    logic [MONEY_W:0] cust_w, mach_w, price_w, diff_w, sum_w;

    assign cust_w  = {1'b0, cust_i};
    assign mach_w  = {1'b0, mach_i};
    assign price_w = {1'b0, price_i};
    assign diff_w  = cust_w - price_w;
    assign sum_w   = mach_w + price_w;

    always_comb begin
        dispense_o = 1'b0;
        change_o   = cust_i;
        new_mach_o = mach_i;
        status_o   = OK;
        if (cust_w < price_w) begin
            status_o = INSUFFICIENT;
        end else if (diff_w > mach_w) begin
            status_o = NO_CHANGE;
        end else if (sum_w > MAX_V) begin
            status_o = FULL;
        end else begin
            dispense_o = 1'b1;
            change_o   = diff_w[MONEY_W-1:0];
            new_mach_o = sum_w[MONEY_W-1:0];
        end
    end

endmodule

// File: rtl/vend_transaction.sv
// Transaction controller behind the money-fetch stage: sequences customer and
// machine money fetches, evaluates the sale and registers the outcome.
module vend_transaction
    import vend_pkg::*;
#(
    parameter int MONEY_W = 4,
    parameter int PRICE_0 = 3,
    parameter int PRICE_1 = 5,
    parameter int PRICE_2 = 7,
    parameter int PRICE_3 = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               cancel,
    input  logic [1:0]         productSel,
    input  logic [MONEY_W-1:0] moneyIn,
    output logic               moneyMode,
    output logic               busy,
    output logic               done,
    output logic               dispense,
    output logic               refund,
    output logic [MONEY_W-1:0] change,
    output logic [MONEY_W-1:0] newMachineMoney,
    output logic               saveEn,
    output logic [2:0]         status
);

    function automatic logic [MONEY_W-1:0] price_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return MONEY_W'(PRICE_0);
            2'd1:    return MONEY_W'(PRICE_1);
            2'd2:    return MONEY_W'(PRICE_2);
            default: return MONEY_W'(PRICE_3);
        endcase
    endfunction

    state_t             state_q;
    status_t            status_q;
    logic [MONEY_W-1:0] cust_q, mach_q, price_q;
    logic [MONEY_W-1:0] change_q, newmach_q;
    logic               busy_q, done_q, dispense_q, refund_q, save_q;

    logic               ev_dispense;
    logic [MONEY_W-1:0] ev_change, ev_newmach;
    status_t            ev_status;
    logic               cancel_hit, cancel_late;

    vend_evaluate #(.MONEY_W(MONEY_W)) u_eval (
        .cust_i     (cust_q),
        .mach_i     (mach_q),
        .price_i    (price_q),
        .dispense_o (ev_dispense),
        .change_o   (ev_change),
        .new_mach_o (ev_newmach),
        .status_o   (ev_status)
    );

    // Once the customer money is captured a cancel has to hand it back.
    assign cancel_late = (state_q == REQ_MACH) || (state_q == CAP_MACH);
    assign cancel_hit  = cancel && ((state_q == REQ_CUST) || (state_q == CAP_CUST) || cancel_late);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            status_q   <= OK;
            cust_q     <= '0;
            mach_q     <= '0;
            price_q    <= '0;
            change_q   <= '0;
            newmach_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dispense_q <= 1'b0;
            refund_q   <= 1'b0;
            save_q     <= 1'b0;
        end else if (cancel_hit) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            refund_q   <= 1'b1;
            change_q   <= cancel_late ? cust_q : '0;
            newmach_q  <= '0;
            status_q   <= CANCEL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ_CUST;
                        busy_q    <= 1'b1;
                        price_q   <= price_of(productSel);
                        change_q  <= '0;
                        newmach_q <= '0;
                        status_q  <= OK;
                    end
                end
                REQ_CUST: state_q <= CAP_CUST;
                CAP_CUST: begin
                    state_q <= REQ_MACH;
                    cust_q  <= moneyIn;
                end
                REQ_MACH: state_q <= CAP_MACH;
                CAP_MACH: begin
                    state_q <= EVAL;
                    mach_q  <= moneyIn;
                end
                EVAL: begin
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    dispense_q <= ev_dispense;
                    refund_q   <= ~ev_dispense;
                    save_q     <= ev_dispense;
                    change_q   <= ev_change;
                    newmach_q  <= ev_newmach;
                    status_q   <= ev_status;
                end
                DONE: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    dispense_q <= 1'b0;
                    refund_q   <= 1'b0;
                    save_q     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign moneyMode       = ((state_q == REQ_CUST) || (state_q == CAP_CUST)) ? MODE_CUSTOMER : MODE_MACHINE;
    assign busy            = busy_q;
    assign done            = done_q;
    assign dispense        = dispense_q;
    assign refund          = refund_q;
    assign saveEn          = save_q;
    assign change          = change_q;
    assign newMachineMoney = newmach_q;
    assign status          = status_q;

endmodule

// File: tb/tb_vend_transaction.sv
// Bench for vend_transaction: directed plan cases plus random transactions,
// checked against a rule-level model of the sale outcome.
module tb_vend_transaction;

    localparam int ST_OK = 0, ST_INS = 1, ST_NOCH = 2, ST_FULL = 3, ST_CAN = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] productSel = 2'd0;
    logic [3:0] moneyIn;
    logic       moneyMode, busy, done, dispense, refund, saveEn;
    logic [3:0] change, newMachineMoney;
    logic [2:0] status;

    int n_tests = 0;
    int n_fail  = 0;

    // Money the fetch stage would return for each mode.
    logic [3:0] cust_v = 4'd0;
    logic [3:0] mach_v = 4'd0;
    logic [3:0] fetch_q = 4'd0;

    always #5 clk = ~clk;

    // Fetch stage: loads the selected source every edge, so a capture on the
    // wrong edge sees the other source.
    always @(posedge clk) fetch_q <= moneyMode ? cust_v : mach_v;
    assign moneyIn = fetch_q;

    vend_transaction dut (
        .clock           (clk),
        .reset_n         (reset_n),
        .start           (start),
        .cancel          (cancel),
        .productSel      (productSel),
        .moneyIn         (moneyIn),
        .moneyMode       (moneyMode),
        .busy            (busy),
        .done            (done),
        .dispense        (dispense),
        .refund          (refund),
        .change          (change),
        .newMachineMoney (newMachineMoney),
        .saveEn          (saveEn),
        .status          (status)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int price(input int sel);
        case (sel)
            0: return 3;
            1: return 5;
            2: return 7;
            default: return 10;
        endcase
    endfunction

    // can_n: cycle after the start edge in which cancel is held (1..4 honoured,
    // 5 = during EVAL, ignored), 0 = no cancel.
    task automatic model(input int sel, input int cust, input int mach, input int can_n,
                         output int disp, output int chg, output int nm, output int st,
                         output int lat);
        int p;
        p    = price(sel);
        disp = 0;
        chg  = cust;
        nm   = mach;
        lat  = 6;
        if (can_n >= 1 && can_n <= 4) begin
            chg = (can_n <= 2) ? 0 : cust;
            nm  = 0;
            st  = ST_CAN;
            lat = can_n + 1;
        end else if (cust < p) st = ST_INS;
        else if (cust - p > mach) st = ST_NOCH;
        else if (mach + p > 15) st = ST_FULL;
        else begin
            st   = ST_OK;
            disp = 1;
            chg  = cust - p;
            nm   = mach + p;
        end
    endtask

    task automatic txn(input string tag, input int sel, input int cust, input int mach,
                       input int can_n, input bit hold);
        int  e_d, e_c, e_n, e_s, e_l, n;
        bit  seen;
        model(sel, cust, mach, can_n, e_d, e_c, e_n, e_s, e_l);
        @(negedge clk);
        chk({tag, ".idle_mode"}, 32'(moneyMode), 0);
        chk({tag, ".idle_busy"}, 32'(busy), 0);
        cust_v     = 4'(cust);
        mach_v     = 4'(mach);
        productSel = 2'(sel);
        start      = 1'b1;
        @(negedge clk);
        n    = 1;
        seen = 1'b0;
        if (!hold) start = 1'b0;
        while (!seen && n <= 12) begin
            if (done) begin
                seen   = 1'b1;
                cancel = 1'b0;
                start  = 1'b0;
                chk({tag, ".latency"}, n, e_l);
                chk({tag, ".dispense"}, 32'(dispense), e_d);
                chk({tag, ".refund"}, 32'(refund), 1 - e_d);
                chk({tag, ".saveEn"}, 32'(saveEn), e_d);
                chk({tag, ".change"}, 32'(change), e_c);
                chk({tag, ".newMach"}, 32'(newMachineMoney), e_n);
                chk({tag, ".status"}, 32'(status), e_s);
                chk({tag, ".done_mode"}, 32'(moneyMode), 0);
            end else begin
                if (n < e_l) chk({tag, ".mode"}, 32'(moneyMode), (n <= 2) ? 1 : 0);
                chk({tag, ".busy"}, 32'(busy), 1);
                if (hold) productSel = 2'($urandom_range(0, 3));
                cancel = (n == can_n);
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            cancel = 1'b0;
            start  = 1'b0;
            chk({tag, ".timeout"}, 0, 1);
        end
        @(negedge clk);
        chk({tag, ".post_done"}, 32'(done), 0);
        chk({tag, ".post_pulses"}, 32'({dispense, refund, saveEn}), 0);
        chk({tag, ".post_busy"}, 32'(busy), 0);
        chk({tag, ".hold_change"}, 32'(change), e_c);
        chk({tag, ".hold_newMach"}, 32'(newMachineMoney), e_n);
        chk({tag, ".hold_status"}, 32'(status), e_s);
    endtask

    task automatic reset_in_eval();
        @(negedge clk);
        cust_v     = 4'd8;
        mach_v     = 4'd4;
        productSel = 2'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_eval.outs", 32'({busy, done, dispense, refund, saveEn}), 0);
        chk("rst_eval.change", 32'(change), 0);
        chk("rst_eval.newMach", 32'(newMachineMoney), 0);
        chk("rst_eval.status", 32'(status), 0);
        chk("rst_eval.mode", 32'(moneyMode), 0);
        @(negedge clk);
        chk("rst_eval.still_idle", 32'(busy), 0);
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        chk("reset.outs", 32'({moneyMode, busy, done, dispense, refund, saveEn}), 0);
        chk("reset.vals", 32'({change, newMachineMoney, status}), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        txn("ok_basic", 1, 8, 4, 0, 0);
        txn("insufficient", 3, 6, 2, 0, 0);
        txn("no_change", 0, 15, 5, 0, 0);
        txn("exact_pay", 0, 3, 5, 0, 0);
        txn("full", 2, 7, 9, 0, 0);
        txn("fill_to_15", 2, 7, 8, 0, 0);
        txn("cancel_capcust", 1, 9, 4, 2, 0);
        txn("cancel_reqmach", 1, 9, 4, 3, 0);
        txn("cancel_eval_ign", 1, 8, 4, 5, 0);
        txn("start_busy", 1, 8, 4, 0, 1);
        reset_in_eval();
        txn("after_reset", 1, 8, 4, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int r, cn;
            r  = $urandom_range(0, 9);
            cn = (r < 5) ? 0 : r - 4;
            txn($sformatf("rnd%0d", i), $urandom_range(0, 3), $urandom_range(0, 15),
                $urandom_range(0, 15), cn, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
